// File: rtl/vend_pkg.sv
// Shared types and constants for the vending change controller.
//   vend_fsm_t        : controller FSM state encoding
//   NUM_CREDIT_STATES : width of the one-hot credit register (S0..S6)
//   QUARTER_W         : width of a quarter count (0..6)
//   DEFAULT_PRICE_Q   : default item price in quarters
package vend_pkg;

  localparam int NUM_CREDIT_STATES = 7;
  localparam int QUARTER_W         = 3;
  localparam int DEFAULT_PRICE_Q   = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VEND     = 3'd1,
    CHG_REQ  = 3'd2,
    CHG_WAIT = 3'd3,
    CLEAR    = 3'd4
  } vend_fsm_t;

endpackage

// File: rtl/vend_change_controller_credit_decoder.sv
// credit_decoder: one-hot credit register -> quarter count.
//   state [6:0] in  : one-hot credit, bit k = k quarters
//   count [2:0] out : index of the set bit (only meaningful when valid)
//   valid       out : exactly one bit of state is set
// Purely combinational.
module credit_decoder
  import vend_pkg::*;
(
  input  logic [NUM_CREDIT_STATES-1:0] state,
  output logic [QUARTER_W-1:0]         count,
  output logic                         valid
);

  localparam logic [NUM_CREDIT_STATES-1:0] ONE = NUM_CREDIT_STATES'(1);

  // OR of the indices of all set bits; equals the index when one-hot.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_CREDIT_STATES; i++) begin
      if (state[i]) count = count | QUARTER_W'(i);
    end
  end

  // Non-zero with no second bit set.
  assign valid = (state != '0) && ((state & (state - ONE)) == '0);

endmodule

// File: rtl/vend_change_controller.sv
// vend_change_controller: vend actuator and change hopper sequencer.
//   CLK          in  : clock, rising edge
//   RES          in  : synchronous active-high reset
//   state[6:0]   in  : one-hot credit register
//   vend_req     in  : single-cycle vend button pulse
//   coin_ack     in  : hopper ack (high = quarter ejected, low = ready)
//   vend_out     out : vend actuator, high VEND_CYCLES cycles
//   quarter_out  out : hopper eject request
//   credit_clear out : one-cycle pulse, forces credit back to S0
//   deny         out : one-cycle pulse on a rejected request
//   busy         out : FSM not idle
//   error        out : combinational, credit not one-hot
// All outputs except error come straight from flops.
module vend_change_controller
  import vend_pkg::*;
#(
  parameter int PRICE_Q     = DEFAULT_PRICE_Q,
  parameter int VEND_CYCLES = 3
) (
  input  logic                         CLK,
  input  logic                         RES,
  input  logic [NUM_CREDIT_STATES-1:0] state,
  input  logic                         vend_req,
  input  logic                         coin_ack,
  output logic                         vend_out,
  output logic                         quarter_out,
  output logic                         credit_clear,
  output logic                         deny,
  output logic                         busy,
  output logic                         error
);

  localparam int                   CYC_W    = (VEND_CYCLES < 2) ? 1 : $clog2(VEND_CYCLES + 1);
  localparam logic [QUARTER_W-1:0] PRICE    = QUARTER_W'(PRICE_Q);
  localparam logic [CYC_W-1:0]     CYC_LOAD = CYC_W'(VEND_CYCLES);
  localparam logic [CYC_W-1:0]     CYC_ONE  = CYC_W'(1);
  localparam logic [QUARTER_W-1:0] Q_ONE    = QUARTER_W'(1);

  vend_fsm_t            fsm_q, fsm_d;
  logic [QUARTER_W-1:0] chg_q, chg_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [QUARTER_W-1:0] credit;
  logic                 valid;
  logic                 deny_d;

  credit_decoder u_dec (
    .state (state),
    .count (credit),
    .valid (valid)
  );

  assign error = !valid;

  always_comb begin
    fsm_d  = fsm_q;
    chg_d  = chg_q;
    cyc_d  = cyc_q;
    deny_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (vend_req) begin
          if (valid && (credit >= PRICE)) begin
            chg_d = credit - PRICE;
            cyc_d = CYC_LOAD;
            fsm_d = VEND;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      VEND: begin
        // Counter starts at VEND_CYCLES; leaving on 1 gives exactly
        // VEND_CYCLES cycles of vend_out.
        cyc_d = cyc_q - CYC_ONE;
        if (cyc_q == CYC_ONE) fsm_d = (chg_q != '0) ? CHG_REQ : CLEAR;
      end
      CHG_REQ: begin
        if (coin_ack) begin
          chg_d = chg_q - Q_ONE;
          fsm_d = CHG_WAIT;
        end
      end
      CHG_WAIT: begin
        // No timeout: a stuck-high ack parks the FSM here.
        if (!coin_ack) fsm_d = (chg_q == '0) ? CLEAR : CHG_REQ;
      end
      CLEAR:   fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with
  // the state they describe, with no input-to-output comb path.
  always_ff @(posedge CLK) begin
    if (RES) begin
      fsm_q        <= IDLE;
      chg_q        <= '0;
      cyc_q        <= '0;
      vend_out     <= 1'b0;
      quarter_out  <= 1'b0;
      credit_clear <= 1'b0;
      deny         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      chg_q        <= chg_d;
      cyc_q        <= cyc_d;
      vend_out     <= (fsm_d == VEND);
      quarter_out  <= (fsm_d == CHG_REQ);
      credit_clear <= (fsm_d == CLEAR);
      deny         <= deny_d;
      busy         <= (fsm_d != IDLE);
    end
  end

endmodule

// File: doc/vend_change_controller.md
Name: vend_change_controller

Overview:
- Downstream consumer of the 7-bit one-hot credit state register (S0 = $0.00 through S6 = $1.50, one bit per $0.25 step).
- On a vend request with sufficient credit: pulses the vend actuator, dispenses change one quarter at a time through a hopper handshake, then requests a credit clear back to S0 from the next-state logic.
- Rejects requests on insufficient credit or an illegal (non-one-hot) state.

Parameters:
- PRICE_Q, 4, item price in quarters (4 = $1.00); legal range 0..6.
- VEND_CYCLES, 3, number of cycles vend_out is held high; must be at least 1.

Ports:
- CLK  input  1  system clock; all logic is rising-edge.
- RES  input  1  synchronous, active-high reset.
- state  input  7  one-hot credit from the state register; bit k means k quarters of credit.
- vend_req  input  1  vend button; single-cycle, already-synchronised pulse.
- coin_ack  input  1  hopper acknowledge; high once a quarter has been ejected, low when the hopper is ready again.
- vend_out  output  1  vend actuator drive.
- quarter_out  output  1  hopper eject request.
- credit_clear  output  1  one-cycle pulse that forces the next state to S0.
- deny  output  1  one-cycle pulse on a rejected request.
- busy  output  1  high whenever the FSM is not in IDLE.
- error  output  1  combinational flag: state is not exactly one-hot.

Behaviour:
- Reset (RES sampled high at a clock edge):
  - FSM goes to IDLE.
  - vend_out, quarter_out, credit_clear, deny and busy are 0.
  - Change counter and cycle counter are 0.
  - Reset mid-vend or mid-change aborts the operation; owed change is lost and no credit_clear is issued.
- Decode:
  - credit = index of the set bit (0..6).
  - valid = exactly one bit set.
  - error = !valid (combinational, not registered).
- States: IDLE, VEND, CHG_REQ, CHG_WAIT, CLEAR.
- IDLE, on vend_req:
  - If valid and credit >= PRICE_Q: latch change = credit - PRICE_Q (3-bit, unsigned, cannot underflow), load cycle counter = VEND_CYCLES, go to VEND.
  - Otherwise: deny = 1 for the next cycle only; stay in IDLE.
- VEND:
  - vend_out = 1; decrement cycle counter each cycle.
  - When the counter reaches 1: go to CHG_REQ if change != 0, else go to CLEAR.
  - vend_out is high for exactly VEND_CYCLES cycles.
- CHG_REQ:
  - quarter_out = 1, held until coin_ack is sampled high.
  - On that edge: change decrements, quarter_out drops to 0 the following cycle, go to CHG_WAIT.
- CHG_WAIT:
  - quarter_out = 0; wait for coin_ack sampled low.
  - Then go to CLEAR if change == 0, else go to CHG_REQ.
  - coin_ack held high indefinitely stalls the FSM here (no timeout).
- CLEAR: credit_clear = 1 for exactly one cycle, then IDLE.
- vend_req while busy is ignored: no deny, not queued.
- The state input is sampled only in IDLE on vend_req. Credit changes during VEND/CHG_* do not alter the latched change.
- coin_ack seen outside CHG_REQ/CHG_WAIT is ignored.
- All outputs except error are registered; no combinational path from inputs to those outputs.
- Latency: vend_req edge to vend_out high is 1 cycle. Last coin_ack fall to credit_clear is 1 cycle.

Decomposition:
- Package vend_pkg:
  - fsm enum (vend_fsm_t, 3-bit).
  - NUM_CREDIT_STATES = 7 and QUARTER_W = 3.
  - Default PRICE_Q constant.
- Sub-module credit_decoder: 7-bit one-hot in; 3-bit count and valid out; purely combinational.

Test Plan:
- Exact price: state=S4 (7'b0010000), vend_req pulse -> vend_out high 3 cycles, quarter_out never asserts, credit_clear pulse 1 cycle after the vend ends, busy high 4 cycles.
- Change of 2: state=S6, vend_req -> vend 3 cycles, then two quarter_out/coin_ack handshakes (ack after 2 cycles each), then credit_clear; exactly 2 quarter_out rising edges.
- Insufficient credit: state=S3 (7'b0001000), vend_req -> deny high exactly 1 cycle, busy stays 0, vend_out stays 0.
- Illegal state: state=7'b0010010, vend_req -> error=1, deny pulse, no vend; then state=7'b0000000 -> error=1.
- Busy ignore and stall: second vend_req during VEND -> no effect; coin_ack held high 10 cycles in CHG_WAIT -> FSM stalls with quarter_out=0 and resumes after ack falls.
- Mid-operation reset: RES asserted during CHG_REQ with change=1 -> next cycle all outputs 0, busy=0, no credit_clear; a subsequent vend at S5 works normally (1 quarter returned).
